// File: rtl/midi_pkg.sv
// midi_pkg: shared status nibbles, running-status kinds and parser FSM states.
package midi_pkg;
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CH_AT    = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;
  localparam logic [3:0] ST_SYS      = 4'hF;
  localparam logic [7:0] RT_THRESH   = 8'hF8;
  typedef enum logic [2:0] {
    KIND_NONE, KIND_NOTE_OFF, KIND_NOTE_ON, KIND_SKIP1, KIND_SKIP2
  } kind_t;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEY  = 2'd1;
  localparam logic [1:0] S_VEL  = 2'd2;
endpackage

// File: rtl/midi_status_decode.sv
// midi_status_decode: classifies a MIDI byte and maps status bytes to a running-status kind.
// MIDI_OMNI_EN makes note-on/off from every channel count as ours.
module midi_status_decode
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic [7:0] i_byte,
  output logic       o_is_realtime,
  output logic       o_is_status,
  output logic       o_is_syscommon,
  output kind_t      o_kind
);
`ifdef MIDI_OMNI_EN
  localparam logic OMNI = 1'b1;
`else
  localparam logic OMNI = 1'b0;
`endif
  logic [3:0] w_hi;
  logic       w_ch_ok;
  always_comb begin
    w_hi           = i_byte[7:4];
    w_ch_ok        = OMNI || (i_byte[3:0] == CHANNEL);
    o_is_realtime  = i_byte >= RT_THRESH;
    o_is_status    = i_byte[7] && (w_hi != ST_SYS);
    o_is_syscommon = (w_hi == ST_SYS) && !o_is_realtime;
    o_kind = !o_is_status ? KIND_NONE :
             (w_hi == ST_NOTE_OFF && w_ch_ok) ? KIND_NOTE_OFF :
             (w_hi == ST_NOTE_ON && w_ch_ok) ? KIND_NOTE_ON :
             (w_hi == ST_PROG || w_hi == ST_CH_AT) ? KIND_SKIP1 :
             (w_hi == ST_NOTE_OFF || w_hi == ST_NOTE_ON || w_hi == ST_POLY_AT ||
              w_hi == ST_CC || w_hi == ST_PITCH) ? KIND_SKIP2 : KIND_NONE;
  end
endmodule

// File: rtl/midi_note_parser.sv
// midi_note_parser: monophonic MIDI note-on/off parser with running status and panic.
// Optional MIDI_OMNI_EN (in midi_status_decode) accepts notes on every channel.
module midi_note_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  input  logic       i_panic,
  output logic [6:0] o_midi,
  output logic [6:0] o_velocity,
  output logic       o_note_valid
);
  logic       w_rt, w_st, w_sc, w_data, w_complete, w_on, w_off, w_kill;
  kind_t      w_kind, r_kind;
  logic [1:0] r_state;
  logic [6:0] r_key, r_midi, r_velocity;
  logic       r_note_valid;

  midi_status_decode #(.CHANNEL(CHANNEL)) u_dec (
    .i_byte         (i_byte),
    .o_is_realtime  (w_rt),
    .o_is_status    (w_st),
    .o_is_syscommon (w_sc),
    .o_kind         (w_kind)
  );

  always_comb begin
    w_data     = i_byte_valid && !i_byte[7];
    w_complete = w_data && (r_state == S_VEL);
    w_on       = w_complete && (r_kind == KIND_NOTE_ON) && (i_byte[6:0] != 7'd0) && (r_key != 7'd0);
    w_off      = w_complete && ((r_kind == KIND_NOTE_OFF) || (r_kind == KIND_NOTE_ON && i_byte[6:0] == 7'd0))
                 && (r_key == r_midi) && (r_midi != 7'd0);
    // panic overrides any completing message for the outputs only
    w_kill     = i_panic ? (r_midi != 7'd0) : w_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_kind  <= KIND_NONE;
      r_key   <= 7'd0;
    end else if (i_byte_valid && !w_rt) begin
      if (w_st) begin
        r_kind  <= w_kind;
        r_state <= S_KEY;
      end else if (w_sc) begin
        r_kind  <= KIND_NONE;
        r_state <= S_IDLE;
      end else if (w_data && r_state == S_KEY && r_kind != KIND_SKIP1) begin
        r_key   <= i_byte[6:0];
        r_state <= S_VEL;
      end else if (w_complete) begin
        r_state <= S_KEY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_midi       <= 7'd0;
      r_velocity   <= 7'd0;
      r_note_valid <= 1'b0;
    end else begin
      r_note_valid <= w_kill || (!i_panic && w_on);
      if (w_kill) begin
        r_midi     <= 7'd0;
        r_velocity <= 7'd0;
      end else if (!i_panic && w_on) begin
        r_midi     <= r_key;
        r_velocity <= i_byte[6:0];
      end
    end
  end

  assign o_midi       = r_midi;
  assign o_velocity   = r_velocity;
  assign o_note_valid = r_note_valid;
endmodule

// File: tb/tb_midi_note_parser.sv
// tb_midi_note_parser: directed and random byte streams checked by a scoreboard against a message-level model.
module tb_midi_note_parser;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_valid = 1'b0;
  logic       i_panic = 1'b0;
  logic [6:0] o_midi, o_velocity;
  logic       o_note_valid;
  int         errors = 0;
  int         checks = 0;
  logic [13:0] exp_q[$];
  logic [7:0] rs;
  logic [6:0] dbuf[$];
  logic [6:0] m_note, m_vel;

  midi_note_parser #(.CHANNEL(4'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .i_panic      (i_panic),
    .o_midi       (o_midi),
    .o_velocity   (o_velocity),
    .o_note_valid (o_note_valid)
  );

  always #5 clk = ~clk;

  function automatic bit chan_ok(input logic [7:0] s);
`ifdef MIDI_OMNI_EN
    return 1'b1;
`else
    return s[3:0] == 4'd0;
`endif
  endfunction

  task automatic model_reset();
    rs = 8'h00;
    dbuf.delete();
    m_note = 7'd0;
    m_vel = 7'd0;
  endtask

  // one clock of input: optional byte plus optional panic
  task automatic model_step(input bit v, input logic [7:0] b, input bit p);
    bit on = 0, off = 0;
    logic [6:0] key = 0, vel = 0;
    int need;
    if (v && b < 8'hF8) begin
      if (b >= 8'hF0) begin rs = 8'h00; dbuf.delete(); end
      else if (b[7]) begin rs = b; dbuf.delete(); end
      else if (rs != 8'h00) begin
        dbuf.push_back(b[6:0]);
        need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
        if (dbuf.size() == need) begin
          if (need == 2 && chan_ok(rs)) begin
            key = dbuf[0];
            vel = dbuf[1];
            on  = rs[7:4] == 4'h9 && vel != 0 && key != 0;
            off = (rs[7:4] == 4'h8 || (rs[7:4] == 4'h9 && vel == 0)) && key == m_note && m_note != 0;
          end
          dbuf.delete();
        end
      end
    end
    if (p) begin
      if (m_note != 0) begin m_note = 0; m_vel = 0; exp_q.push_back(14'd0); end
    end else if (on) begin
      m_note = key; m_vel = vel; exp_q.push_back({key, vel});
    end else if (off) begin
      m_note = 0; m_vel = 0; exp_q.push_back(14'd0);
    end
  endtask

  // caller is #1 after a rising edge
  task automatic send(input logic [7:0] b, input bit p);
    i_byte = b;
    i_byte_valid = 1'b1;
    i_panic = p;
    model_step(1'b1, b, p);
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
    i_panic = 1'b0;
  endtask

  task automatic idle(input bit p);
    i_panic = p;
    model_step(1'b0, 8'h00, p);
    @(posedge clk); #1;
    i_panic = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) send(s[i], 1'b0);
  endtask

  task automatic check_state(input string name);
    checks++;
    if (o_midi !== m_note || o_velocity !== m_vel) begin
      errors++;
      $display("FAIL %s: got midi=%h vel=%h expected midi=%h vel=%h", name, o_midi, o_velocity, m_note, m_vel);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_note_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse: unexpected o_note_valid with midi=%h vel=%h, none expected", o_midi, o_velocity);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        if ({o_midi, o_velocity} !== e) begin
          errors++;
          $display("FAIL pulse: got midi=%h vel=%h expected midi=%h vel=%h", o_midi, o_velocity, e[13:7], e[6:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    model_reset();
    #12;
    checks++;
    if (o_midi !== 0 || o_velocity !== 0 || o_note_valid !== 0) begin
      errors++;
      $display("FAIL reset: got midi=%h vel=%h nv=%b expected 0 0 0", o_midi, o_velocity, o_note_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_seq('{8'h90, 8'h45, 8'h64});
    check_state("note_on");
    send_seq('{8'h48, 8'h20});
    check_state("running_status");
    send_seq('{8'h45, 8'h00});
    check_state("off_not_current");
    send_seq('{8'h90, 8'h45, 8'h64, 8'h80, 8'h45, 8'h40});
    check_state("note_off");
    send_seq('{8'h91, 8'h30, 8'h7F});
    check_state("other_channel");
    send_seq('{8'h90, 8'h3C, 8'hF8, 8'h50});
    check_state("realtime_mid");
    send_seq('{8'hC0, 8'h05, 8'hB0, 8'h07, 8'h7F});
    check_state("skip_msgs");
    send_seq('{8'h90, 8'h3C, 8'h50, 8'hF0, 8'h45, 8'h7F, 8'hF7, 8'h45, 8'h10});
    check_state("sysex_idle");
    send_seq('{8'h90, 8'h00, 8'h40});
    check_state("key_zero");
    send_seq('{8'h90, 8'h3C, 8'h50, 8'h90, 8'h50});
    send(8'h40, 1'b1);
    check_state("panic_wins");
    idle(1'b1);
    check_state("panic_silent");
    send_seq('{8'h90, 8'h3C, 8'h50, 8'h90});
    send(8'h3C, 1'b0);
    send(8'h50, 1'b0);
    check_state("same_note_retrigger");
    send(8'h45, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_seq('{8'h45, 8'h10});
    check_state("data_after_reset");
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 12) begin
        logic [7:0] st[9];
        st = '{8'h80, 8'h90, 8'h90, 8'h81, 8'h91, 8'hA0, 8'hB0, 8'hC0, 8'hE0};
        b = st[$urandom_range(0, 8)];
      end else if (r < 15) b = 8'hF0 | 8'($urandom_range(0, 7));
      else if (r < 18) b = 8'hF8 | 8'($urandom_range(0, 7));
      else if (r < 30) b = 8'h00;
      else if (r < 70) b = 8'h3C + 8'($urandom_range(0, 3));
      else b = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(0, 3) == 0);
      else send(b, $urandom_range(0, 19) == 0);
      if (n % 100 == 99) check_state("random_state");
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
